// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default widths and frame
// byte constants for the UART command sequencer.
package uart_pkg;

  localparam int DEF_MAX_BYTES  = 8;
  localparam int DEF_INTERVAL_W = 20;
  localparam int DEF_CNT_W      = 16;

  localparam logic [7:0] START_BYTE = 8'h01;
  localparam logic [7:0] READ_CMD   = 8'h02;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    INTERVAL
  } state_e;

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// uart_cmd_sequencer_if: byte request/done handshake between the
// sequencer (master) and the UART transmitter (slave).
interface uart_cmd_sequencer_if;

  logic [7:0] tx_data_p;
  logic       tx_req_p;
  logic       tx_done_p;

  modport master (
    output tx_data_p,
    output tx_req_p,
    input  tx_done_p
  );

  modport slave (
    input  tx_data_p,
    input  tx_req_p,
    output tx_done_p
  );

endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: MAX_BYTES x 8 frame register file, one write
// port gated by the parent's idle flag, one combinational read.
module uart_frame_buf
  import uart_pkg::*;
#(
  parameter  int MAX_BYTES = DEF_MAX_BYTES,
  localparam int ADDR_W    = $clog2(MAX_BYTES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic              idle_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o
);

  logic [7:0] mem_q [MAX_BYTES];
  logic       addr_ok;
  logic       wr_ok;

  // Non power-of-two depths must drop out-of-range addresses.
  if (MAX_BYTES == (1 << ADDR_W)) begin : g_pow2
    assign addr_ok = 1'b1;
  end else begin : g_chk
    assign addr_ok =
      {1'b0, wr_addr_i} < (ADDR_W+1)'(MAX_BYTES);
  end

  assign wr_ok = we_i && idle_i && addr_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: streams a programmable byte frame into a UART
// transmitter, single-shot or periodic, with graceful abort.
module uart_cmd_sequencer
  import uart_pkg::*;
#(
  parameter  int MAX_BYTES  = DEF_MAX_BYTES,
  parameter  int INTERVAL_W = DEF_INTERVAL_W,
  parameter  int CNT_W      = DEF_CNT_W,
  localparam int ADDR_W     = $clog2(MAX_BYTES)
) (
  input  logic                  clk210_p,
  input  logic                  reset_n_p,
  input  logic                  buf_wr_en_p,
  input  logic [ADDR_W-1:0]     buf_wr_addr_p,
  input  logic [7:0]            buf_wr_data_p,
  input  logic [ADDR_W:0]       frame_len_p,
  input  logic [INTERVAL_W-1:0] interval_p,
  input  logic                  repeat_p,
  input  logic                  start_p,
  input  logic                  abort_p,
  uart_cmd_sequencer_if.master  tx,
  output logic                  busy_p,
  output logic                  frame_done_p,
  output logic [CNT_W-1:0]      frame_count_p
);

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(MAX_BYTES);

  state_e                state_q;
  logic [ADDR_W-1:0]     idx_q;
  logic [ADDR_W:0]       len_q;
  logic [INTERVAL_W-1:0] ival_q;
  logic [INTERVAL_W-1:0] cnt_q;
  logic                  rpt_q;
  logic                  abort_q;
  logic [7:0]            data_q;
  logic                  req_q;
  logic                  fdone_q;
  logic [CNT_W-1:0]      fcnt_q;

  logic              idle;
  logic              last;
  logic              ab;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  assign idle = (state_q == IDLE);
  assign last = ({1'b0, idx_q} == len_q - 1'b1);
  assign ab   = abort_q | abort_p;

  // Read address is the byte the next SEND will present.
  assign rd_addr = (state_q == GAP && !last) ? idx_q + 1'b1 : '0;

  uart_frame_buf #(
    .MAX_BYTES (MAX_BYTES)
  ) u_buf (
    .clk_i     (clk210_p),
    .rst_ni    (reset_n_p),
    .we_i      (buf_wr_en_p),
    .idle_i    (idle),
    .wr_addr_i (buf_wr_addr_p),
    .wr_data_i (buf_wr_data_p),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_ff @(posedge clk210_p or negedge reset_n_p) begin
    if (!reset_n_p) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      ival_q  <= '0;
      cnt_q   <= '0;
      rpt_q   <= 1'b0;
      abort_q <= 1'b0;
      data_q  <= '0;
      req_q   <= 1'b0;
      fdone_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      fdone_q <= 1'b0;
      if (!idle && abort_p) abort_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (start_p && frame_len_p != '0) begin
            len_q   <= (frame_len_p > MAX_LEN) ?
                       MAX_LEN : frame_len_p;
            ival_q  <= interval_p;
            rpt_q   <= repeat_p;
            idx_q   <= '0;
            data_q  <= rd_data;
            req_q   <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (tx.tx_done_p) begin
            req_q   <= 1'b0;
            state_q <= GAP;
            if (last) begin
              fdone_q <= 1'b1;
              fcnt_q  <= fcnt_q + 1'b1;
            end
          end
        end
        GAP: begin
          if (!last) begin
            idx_q <= idx_q + 1'b1;
            if (ab) begin
              abort_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              data_q  <= rd_data;
              req_q   <= 1'b1;
              state_q <= SEND;
            end
          end else if (ab || !rpt_q) begin
            abort_q <= 1'b0;
            state_q <= IDLE;
          end else if (ival_q == '0) begin
            idx_q   <= '0;
            data_q  <= rd_data;
            req_q   <= 1'b1;
            state_q <= SEND;
          end else begin
            cnt_q   <= '0;
            state_q <= INTERVAL;
          end
        end
        INTERVAL: begin
          if (ab) begin
            abort_q <= 1'b0;
            state_q <= IDLE;
          end else if (cnt_q == ival_q - 1'b1) begin
            idx_q   <= '0;
            data_q  <= rd_data;
            req_q   <= 1'b1;
            state_q <= SEND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_data_p  = data_q;
  assign tx.tx_req_p   = req_q;
  assign busy_p        = !idle;
  assign frame_done_p  = fdone_q;
  assign frame_count_p = fcnt_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: randomized bench with a transaction-level
// model of frames, gaps, aborts and counters.
module tb_uart_cmd_sequencer;
  import uart_pkg::*;

  localparam int MAXB = 8;
  localparam int IW   = 20;
  localparam int CW   = 16;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic [AW:0]   flen = '0;
  logic [IW-1:0] ival = '0;
  logic          rpt = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          busy;
  logic          fdone;
  logic [CW-1:0] fcount;

  uart_cmd_sequencer_if tx_if();

  uart_cmd_sequencer #(
    .MAX_BYTES (MAXB),
    .INTERVAL_W(IW),
    .CNT_W     (CW)
  ) dut (
    .clk210_p     (clk),
    .reset_n_p    (rst_n),
    .buf_wr_en_p  (wr_en),
    .buf_wr_addr_p(wr_addr),
    .buf_wr_data_p(wr_data),
    .frame_len_p  (flen),
    .interval_p   (ival),
    .repeat_p     (rpt),
    .start_p      (start),
    .abort_p      (abort),
    .tx           (tx_if),
    .busy_p       (busy),
    .frame_done_p (fdone),
    .frame_count_p(fcount)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nchk  = 0;

  // Model state: what the spec says should be on the wire.
  logic [7:0] mbuf [MAXB];
  logic [7:0] mf   [MAXB];
  bit   m_on, m_rpt, m_abort, m_first, hold, prev_req;
  int   m_len, m_int, m_pos, m_frames;
  int   low_run, run_fd, iframe_gap;
  logic [7:0] exp_data;
  logic [7:0] seen [$];

  int fixed_lat = 10;
  bit spur = 1'b0;
  int age = 0;
  int lat = 10;
  bit given = 1'b0;
  bit chk_low = 1'b0;

  function automatic void chk(string nm, longint act, longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, want %0d at %0t",
                  nm, act, exp, $time);
  endfunction

  function automatic void model_reset();
    foreach (mbuf[i]) mbuf[i] = '0;
    m_on = 0; m_abort = 0; hold = 0; prev_req = 0;
    m_pos = 0; m_frames = 0; low_run = 0;
    exp_data = '0;
  endfunction

  function automatic int seen_at(int k);
    return (seen.size() > k) ? int'(seen[k]) : -1;
  endfunction

  function automatic void monitor_step();
    bit req;
    bit efd;
    req = tx_if.tx_req_p;
    efd = 1'b0;
    if (req && !prev_req) begin
      chk("req_expected", req && m_on, 1);
      if (m_on) begin
        if (!m_first) begin
          chk("req_gap", low_run, (m_pos == 0) ? 1 + m_int : 1);
          if (m_pos == 0) iframe_gap = low_run;
        end
        m_first  = 0;
        exp_data = mf[m_pos];
        seen.push_back(tx_if.tx_data_p);
      end
    end
    if (!req && prev_req && m_on) begin
      m_pos++;
      if (m_pos == m_len) begin
        m_pos = 0;
        m_frames++;
        efd = 1'b1;
        run_fd++;
        if (!m_rpt) begin m_on = 0; hold = 1; end
      end
      if (m_abort) begin m_on = 0; hold = 1; end
    end
    chk("tx_data", tx_if.tx_data_p, exp_data);
    chk("frame_done", fdone, efd);
    chk("frame_count", fcount, m_frames % 65536);
    chk("busy", busy, m_on || hold);
    hold     = 0;
    low_run  = req ? 0 : low_run + 1;
    prev_req = req;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      else monitor_step();
    end
  end

  // Transmitter: done after a latency, plus spurious done while idle.
  initial begin
    tx_if.tx_done_p = 1'b0;
    forever begin
      @(negedge clk);
      tx_if.tx_done_p = 1'b0;
      if (!rst_n) begin
        age = 0; given = 0; chk_low = 0;
      end else begin
        if (chk_low) begin
          chk("req_low_after_done", tx_if.tx_req_p, 0);
          chk_low = 0;
        end
        if (tx_if.tx_req_p) begin
          age++;
          if (age == lat) begin
            tx_if.tx_done_p = 1'b1;
            given = 1; chk_low = 1;
          end
        end else begin
          if (age > 0) chk("req_held_until_done", given, 1);
          age = 0; given = 0;
          lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 12);
          if (spur && $urandom_range(0, 7) == 0)
            tx_if.tx_done_p = 1'b1;
        end
      end
    end
  end

  task automatic finish_run();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(int a, logic [7:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    if (!m_on) mbuf[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(int len, int iv, bit rp, bit with_ab);
    flen = (AW+1)'(len); ival = IW'(iv); rpt = rp;
    start = 1'b1; abort = with_ab;
    tick();
    start = 1'b0; abort = 1'b0;
    if (len != 0) begin
      m_on = 1; m_len = (len > MAXB) ? MAXB : len;
      m_int = iv; m_rpt = rp; m_pos = 0; m_first = 1;
      m_abort = 0; run_fd = 0;
      foreach (mf[i]) mf[i] = mbuf[i];
      seen.delete();
    end
  endtask

  task automatic do_abort();
    abort = 1'b1;
    if (m_on) begin
      if (tx_if.tx_req_p) m_abort = 1;
      else begin m_on = 0; hold = 1; end
    end
    tick();
    abort = 1'b0;
  endtask

  task automatic timeout(string nm);
    nchk++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
    finish_run();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_on && n < 5000) begin tick(); n++; end
    if (m_on) timeout("wait_idle");
    tick(2);
  endtask

  task automatic wait_frames(int f);
    int n = 0;
    while (m_frames < f && n < 5000) begin tick(); n++; end
    if (m_frames < f) timeout("wait_frames");
  endtask

  task automatic wait_byte(int p);
    int n = 0;
    while (!(tx_if.tx_req_p && m_pos == p) && n < 500) begin
      tick(); n++;
    end
    if (n >= 500) timeout("wait_byte");
  endtask

  initial begin
    #600000;
    timeout("watchdog");
  end

  initial begin
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_req", tx_if.tx_req_p, 0);
    chk("rst_data", tx_if.tx_data_p, 0);
    chk("rst_fdone", fdone, 0);
    chk("rst_fcount", fcount, 0);
    rst_n = 1'b1;
    tick(2);

    // Single-shot frame 01 02 00 04, done 10 cycles after req.
    do_write(0, START_BYTE);
    do_write(1, READ_CMD);
    do_write(2, 8'h00);
    do_write(3, 8'h04);
    do_write(4, 8'h5A);
    do_start(4, 0, 0, 0);
    wait_idle();
    chk("ss_b0", seen_at(0), 'h01);
    chk("ss_b1", seen_at(1), 'h02);
    chk("ss_b2", seen_at(2), 'h00);
    chk("ss_b3", seen_at(3), 'h04);
    chk("ss_nbytes", seen.size(), 4);
    chk("ss_fdone", run_fd, 1);
    chk("ss_fcount", fcount, 1);
    chk("ss_busy", busy, 0);

    // Periodic, interval 5, then abort inside INTERVAL.
    fixed_lat = 0;
    do_start(3, 5, 1, 0);
    wait_frames(4);
    chk("rep_gap", iframe_gap, 6);
    chk("rep_fcount", fcount, 4);
    do_abort();
    tick(2);
    chk("rep_abort_busy", busy, 0);
    chk("rep_abort_req", tx_if.tx_req_p, 0);

    // Abort while byte 1 is in flight.
    do_start(4, 0, 0, 0);
    wait_byte(1);
    do_abort();
    wait_idle();
    chk("ab_fdone", run_fd, 0);
    chk("ab_nbytes", seen.size(), 2);
    chk("ab_fcount", fcount, 4);

    // Start with simultaneous abort proceeds; write while busy drops.
    do_start(4, 0, 0, 1);
    do_write(0, 8'hAA);
    wait_idle();
    chk("sa_fdone", run_fd, 1);
    do_start(4, 0, 0, 0);
    wait_idle();
    chk("wb_b0", seen_at(0), 'h01);
    chk("wb_fcount", fcount, 6);

    // Zero length is ignored; oversize length clamps.
    do_start(0, 0, 0, 0);
    tick(4);
    chk("len0_busy", busy, 0);
    chk("len0_req", tx_if.tx_req_p, 0);
    do_start(15, 0, 0, 0);
    wait_idle();
    chk("len15_nbytes", seen.size(), 8);
    chk("len15_b4", seen_at(4), 'h5A);

    // Reset mid-byte, then a normal frame.
    do_start(4, 0, 0, 0);
    wait_byte(1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_req", tx_if.tx_req_p, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_fcount", fcount, 0);
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick();
    do_start(2, 0, 0, 0);
    wait_idle();
    chk("post_rst_b0", seen_at(0), 'h00);
    do_write(0, START_BYTE);
    do_write(1, 8'h33);
    do_start(2, 0, 0, 0);
    wait_idle();
    chk("post_rst_b1", seen_at(1), 'h33);
    chk("post_rst_fcount", fcount, 2);

    // Randomized runs.
    spur = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int nw;
      int len;
      int iv;
      bit rp;
      nw = $urandom_range(0, 4);
      for (int w = 0; w < nw; w++)
        do_write($urandom_range(0, MAXB - 1), 8'($urandom));
      len = $urandom_range(0, 15);
      iv  = $urandom_range(0, 6);
      rp  = 1'($urandom);
      do_start(len, iv, rp, ($urandom_range(0, 3) == 0));
      if (len == 0) begin
        tick(3);
      end else if (rp) begin
        tick($urandom_range(5, 120));
        if ($urandom_range(0, 1) == 1) begin
          flen = (AW+1)'($urandom_range(1, 15));
          start = 1'b1;
          tick();
          start = 1'b0;
        end
        tick($urandom_range(0, 30));
        do_abort();
        wait_idle();
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          tick($urandom_range(0, 40));
          do_abort();
        end
        wait_idle();
      end
    end
    tick(5);
    finish_run();
  end

endmodule
